// File: rtl/tile_writeback_dma.sv
// tile_writeback_dma: captures an accumulator tile, shifts/saturates each element and writes it row-major into DRAM
module tile_writeback_dma #(
  parameter int TILE_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MATRIX_SIZE = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] result_flat,
  input  logic [ADDR_WIDTH-1:0]                   dst_base,
  input  logic [$clog2(MATRIX_SIZE+1)-1:0]        matrix_size,
  input  logic [ADDR_WIDTH-1:0]                   tile_row,
  input  logic [ADDR_WIDTH-1:0]                   tile_col,
  input  logic [4:0]                              shift,
  output logic                                    dram_wr_valid,
  input  logic                                    dram_wr_ready,
  output logic [ADDR_WIDTH-1:0]                   dram_addr,
  output logic [DATA_WIDTH-1:0]                   dram_data,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);
  localparam int CNTW = $clog2(TILE_SIZE + 1);
  localparam int CW = ADDR_WIDTH + CNTW + 1;
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
  localparam logic [CNTW-1:0] LAST = CNTW'(TILE_SIZE - 1);
  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
  state_t state_q, state_d;
  logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] tile_q, tile_d;
  logic [4:0] shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d, row_q, row_d, addr_q, addr_d;
  logic [CNTW-1:0] r_q, r_d, c_q, c_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic err_q, err_d;
  logic [CW-1:0] row_end, col_end;
  logic [ADDR_WIDTH-1:0] n_a, first_addr;
  logic in_range, hs, last;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic [ACC_WIDTH-1:0] a, input logic [4:0] sh);
    logic signed [ACC_WIDTH-1:0] s;
    s = $signed(a) >>> sh;
    return s > MAXV ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : s < MINV ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : s[DATA_WIDTH-1:0];
  endfunction

  assign n_a = ADDR_WIDTH'(matrix_size);
  assign row_end = (CW'(tile_row) + CW'(1)) * CW'(TILE_SIZE);
  assign col_end = (CW'(tile_col) + CW'(1)) * CW'(TILE_SIZE);
  assign in_range = matrix_size != '0 && row_end <= CW'(matrix_size) && col_end <= CW'(matrix_size);
  assign first_addr = dst_base + tile_row * ADDR_WIDTH'(TILE_SIZE) * n_a + tile_col * ADDR_WIDTH'(TILE_SIZE);
  assign hs = state_q == WRITE && dram_wr_ready;
  assign last = r_q == LAST && c_q == LAST;

  always_comb begin
    state_d = state_q;
    tile_d = tile_q;
    shift_d = shift_q;
    n_d = n_q;
    row_d = row_q;
    r_d = r_q;
    c_d = c_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d = 1'b0;
    if (state_q == IDLE && start && in_range) begin
      state_d = WRITE;
      tile_d = result_flat;
      shift_d = shift;
      n_d = n_a;
      row_d = first_addr;
      r_d = '0;
      c_d = '0;
      addr_d = first_addr;
      data_d = sat(result_flat[ACC_WIDTH-1:0], shift);
    end else if (state_q == IDLE && start) begin
      err_d = 1'b1;
    end else if (hs && last) begin
      state_d = FINISH;
    end else if (hs) begin
      r_d = c_q == LAST ? r_q + CNTW'(1) : r_q;
      c_d = c_q == LAST ? '0 : c_q + CNTW'(1);
      row_d = c_q == LAST ? row_q + n_q : row_q;
      addr_d = c_q == LAST ? row_q + n_q : addr_q + ADDR_WIDTH'(1);
      data_d = sat(tile_q[(int'(r_d) * TILE_SIZE + int'(c_d)) * ACC_WIDTH +: ACC_WIDTH], shift_q);
    end else if (state_q == FINISH) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tile_q <= '0;
      shift_q <= '0;
      n_q <= '0;
      row_q <= '0;
      r_q <= '0;
      c_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q <= tile_d;
      shift_q <= shift_d;
      n_q <= n_d;
      row_q <= row_d;
      r_q <= r_d;
      c_q <= c_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end

  assign dram_wr_valid = state_q == WRITE;
  assign busy = state_q == WRITE;
  assign done = state_q == FINISH;
  assign err = err_q;
  assign dram_addr = addr_q;
  assign dram_data = data_q;
endmodule

// File: tb/tb_tile_writeback_dma.sv
// tb_tile_writeback_dma: scoreboard bench driving directed tiles and checking every DRAM write
module tb_tile_writeback_dma;
  localparam int T = 4;
  localparam int ACC = 32;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = $clog2(16 + 1);
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [T*T*ACC-1:0] flat = '0;
  logic [AW-1:0] base = '0, tr = '0, tc = '0;
  logic [MW-1:0] n = '0;
  logic [4:0] sh = '0;
  logic ready = 1'b1;
  logic valid, busy, done, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [31:0] acc [T*T];
  exp_t q[$];
  int n_chk = 0, n_pass = 0, hs_cnt = 0, done_cnt = 0;

  tile_writeback_dma dut (
    .clk(clk), .rst(rst), .start(start), .result_flat(flat), .dst_base(base),
    .matrix_size(n), .tile_row(tr), .tile_col(tc), .shift(sh),
    .dram_wr_valid(valid), .dram_wr_ready(ready), .dram_addr(addr), .dram_data(data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic pack();
    for (int i = 0; i < T*T; i++) flat[i*ACC +: ACC] = acc[i];
  endtask

  task automatic push(input int a, input int d);
    q.push_back('{a: AW'(a), d: DW'(d)});
  endtask

  task automatic push_basic();
    for (int i = 0; i < T*T; i++) push(16'h0348 + (i / T) * 16 + i % T, i);
  endtask

  task automatic start_tile(input int b, input int nn, input int r, input int c, input int s);
    base = AW'(b); n = MW'(nn); tr = AW'(r); tc = AW'(c); sh = 5'(s);
    hs_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    logic stalled;
    logic [AW-1:0] st_a;
    logic [DW-1:0] st_d;
    exp_t e;
    stalled = 1'b0;
    st_a = '0;
    st_d = '0;
    forever begin
      @(negedge clk);
      if (valid && stalled) begin
        chk("stall_addr", addr, st_a);
        chk("stall_data", data, st_d);
      end
      stalled = valid && !ready;
      st_a = addr;
      st_d = data;
      if (valid && ready) begin
        hs_cnt++;
        if (q.size() == 0) chk("extra_write", addr, 32'hdead);
        else begin
          e = q.pop_front();
          chk("wr_addr", addr, e.a);
          chk("wr_data", data, e.d);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_queue_empty", q.size(), 0);
        chk("done_busy", busy, 0);
        chk("done_writes", hs_cnt, T*T);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, d0, stall;
    logic [15:0] sat0 [5] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0] sat4 [5] = '{16'h1000, 16'hF000, 16'h07FF, 16'hF800, 16'h2800};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    for (int i = 0; i < T*T; i++) acc[i] = 32'(i);
    pack();
    push_basic();
    start_tile(16'h0300, 16, 1, 2, 0);
    @(negedge clk);
    chk("first_valid", valid, 1);
    chk("first_busy", busy, 1);
    wait_done(1, k);
    chk("basic_latency", k, 17);
    push_basic();
    d0 = done_cnt;
    stall = 0;
    start_tile(16'h0300, 16, 1, 2, 0);
    for (int j = 0; j < 300 && done_cnt == d0; j++) begin
      if (hs_cnt == 9 && stall < 5) begin
        ready = 1'b0;
        stall++;
      end else ready = (j % 4 == 0) || (j % 4 == 3);
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    chk("bp_done_count", done_cnt, d0 + 1);
    chk("bp_stall_len", stall, 5);
    acc[0] = 32'h00010000; acc[1] = 32'hFFFF0000; acc[2] = 32'h00007FFF;
    acc[3] = 32'hFFFF8000; acc[4] = 32'h00028000;
    for (int i = 5; i < T*T; i++) acc[i] = 32'(i * 16);
    pack();
    for (int i = 0; i < T*T; i++) push(16'h0348 + (i / T) * 16 + i % T, i < 5 ? int'(sat0[i]) : i * 16);
    start_tile(16'h0300, 16, 1, 2, 0);
    wait_done(0, k);
    for (int i = 0; i < T*T; i++) push(16'h0348 + (i / T) * 16 + i % T, i < 5 ? int'(sat4[i]) : i);
    start_tile(16'h0300, 16, 1, 2, 4);
    wait_done(0, k);
    start_tile(16'h0300, 16, 0, 4, 0);
    @(negedge clk);
    chk("err_col_pulse", err, 1);
    chk("err_col_valid", valid, 0);
    chk("err_col_busy", busy, 0);
    @(negedge clk);
    chk("err_col_one_cycle", err, 0);
    chk("err_col_idle", busy, 0);
    start_tile(16'h0300, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_n0_pulse", err, 1);
    chk("err_n0_valid", valid, 0);
    @(negedge clk);
    chk("err_writes", hs_cnt, 0);
    for (int i = 0; i < T*T; i++) acc[i] = 32'(i);
    pack();
    push_basic();
    start_tile(16'h0300, 16, 1, 2, 0);
    for (int j = 0; j < 50 && hs_cnt < 5; j++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < T*T; i++) flat[i*ACC +: ACC] = 32'h00001234;
    base = 16'h1000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_start_ignored", busy, 1);
    wait_done(0, k);
    base = 16'h0300;
    pack();
    for (int i = 0; i < 7; i++) push((16'hFFF0 + (i / T) * 16 + i % T) & 16'hFFFF, i);
    start_tile(16'hFFF0, 16, 0, 0, 0);
    for (int j = 0; j < 50 && hs_cnt < 7; j++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_busy", busy, 0);
    chk("wrap_queue_drained", q.size(), 0);
    rst = 1'b0;
    ready = 1'b1;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("no_write_after_rst", hs_cnt, 7);
    push_basic();
    start_tile(16'h0300, 16, 1, 2, 0);
    wait_done(0, k);
    chk("after_rst_latency", k, 17);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tile_writeback_dma.md
Name: tile_writeback_dma

Overview:
- Write-direction counterpart of the tile load DMAs (dma_a/dma_b) that feed SystolicArray_Tiled.
- On start, it captures one TILE_SIZE x TILE_SIZE accumulator result tile from the array.
- Each element is arithmetic-shifted right and saturated to DATA_WIDTH.
- Elements are streamed into DRAM at the tile's position inside the MATRIX_SIZE x MATRIX_SIZE row-major output matrix, over a valid/ready write port.

Parameters:
- TILE_SIZE, 4, tile edge length; elements per tile = TILE_SIZE*TILE_SIZE.
- DATA_WIDTH, 16, DRAM word width; signed output element width.
- ACC_WIDTH, 32, signed accumulator width of each result element.
- ADDR_WIDTH, 16, DRAM word-address width.
- MATRIX_SIZE, 16, maximum matrix edge; sets the width of the matrix_size input.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request one tile writeback; sampled only in IDLE.
- result_flat  in  TILE_SIZE*TILE_SIZE*ACC_WIDTH  element i=r*TILE_SIZE+c at bits [i*ACC_WIDTH +: ACC_WIDTH]; sampled on accepted start.
- dst_base  in  ADDR_WIDTH  DRAM word address of output matrix element (0,0); sampled on accepted start.
- matrix_size  in  clog2(MATRIX_SIZE+1)  runtime matrix edge N; sampled on accepted start.
- tile_row  in  ADDR_WIDTH  tile row index; sampled on accepted start.
- tile_col  in  ADDR_WIDTH  tile column index; sampled on accepted start.
- shift  in  5  arithmetic right-shift amount, 0..31; sampled on accepted start.
- dram_wr_valid  out  1  write request valid.
- dram_wr_ready  in  1  DRAM accepts the write when valid&&ready at a rising edge.
- dram_addr  out  ADDR_WIDTH  write word address.
- dram_data  out  DATA_WIDTH  write data.
- busy  out  1  high in WRITE state.
- done  out  1  one-cycle pulse after the last write is accepted.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset values: dram_wr_valid=0, dram_addr=0, dram_data=0, busy=0, done=0, err=0; state=IDLE; counters=0.
- rst has priority over all other inputs. Reset mid-transfer aborts: no further writes, no done pulse, returns to IDLE.
- States: IDLE, WRITE, FINISH.
- IDLE, start=1, range check:
  - Check: (tile_row+1)*TILE_SIZE <= N, (tile_col+1)*TILE_SIZE <= N, and N != 0.
  - Pass: capture all inputs into an internal tile buffer; r=c=0; go to WRITE.
  - Fail: pulse err next cycle, stay in IDLE, issue no writes.
- start while busy or in FINISH is ignored. result_flat may change freely once start is accepted.
- WRITE:
  - dram_wr_valid=1, with dram_addr/dram_data registered for element (r,c).
  - First valid is asserted in the cycle after the accepted start.
  - While valid && !ready, addr and data hold stable.
  - On a handshake, advance c, wrapping to 0 and incrementing r. The next element is presented in the next cycle (one write per cycle at full ready).
  - After the handshake of element (TILE_SIZE-1, TILE_SIZE-1), deassert valid and go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. busy=0 in FINISH.
- Address for element (r,c): dst_base + (tile_row*TILE_SIZE + r)*N + tile_col*TILE_SIZE + c.
  - Computed at full precision, truncated modulo 2^ADDR_WIDTH; the wrap is silent.
  - Incremental implementation is allowed: row base += N per row.
- Data conversion:
  - s = acc >>> shift, sign-preserving.
  - If s > 2^(DATA_WIDTH-1)-1, output 0x7FFF (DATA_WIDTH=16). If s < -2^(DATA_WIDTH-1), output 0x8000. Otherwise output s[DATA_WIDTH-1:0].
- Write order: row-major within the tile; exactly TILE_SIZE*TILE_SIZE writes per accepted start.
- Minimum latency with ready held high: start accepted at cycle 0; writes at cycles 1..16; done at cycle 17; next start accepted at cycle 18 (TILE_SIZE=4).

Test Plan:
- Basic tile: N=16, dst_base=0x0300, tile (1,2), shift=0, acc[i]=i, ready=1 -> 16 writes; first addr 0x0300+4*16+8=0x0348, data 0; last addr 0x0300+7*16+11=0x037B, data 15; done at cycle 17; busy low at done.
- Backpressure: same setup, ready toggled 1,0,0,1,... and held low 5 cycles at element 9 -> addr/data stable while stalled; no element dropped or duplicated; done only after the 16th handshake.
- Saturation/shift: acc = {0x00010000, 0xFFFF0000, 0x00007FFF, 0xFFFF8000, 0x00028000,...}, shift=0 -> 0x7FFF, 0x8000, 0x7FFF, 0x8000, 0x7FFF. With shift=4: 0x1000, 0xF000, 0x07FF, 0xF800, 0x2800.
- Range error: N=16, tile_col=4 -> err pulse one cycle later, no dram_wr_valid, busy stays 0. Also N=0 -> err.
- Start while busy plus input change: second start at write 5 with different result_flat/dst_base -> ignored; all 16 writes use the captured values.
- Address wrap and reset: dst_base=0xFFF0, tile (0,0), N=16 -> element (1,0) addr 0x0000. Then rst asserted at write 7 -> valid=0 and done=0 the next cycle; a fresh start afterward behaves as the basic-tile test.
